// File: rtl/haraka_aes_inv_iter.sv
// haraka_aes_inv_iter: iterative inverse Haraka AES round engine, one inverse round per clock
module haraka_aes_inv_iter #(
  parameter int NROUNDS = 2,
  parameter int IDXW = (NROUNDS > 1) ? $clog2(NROUNDS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  output logic [IDXW-1:0] rc_idx,
  input  logic [127:0]    rc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [IDXW-1:0] LAST = IDXW'(NROUNDS - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [127:0]    st_q, st_d, rnd;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // multiplicative inverse as a^254; zero maps to zero for free
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(a15, a15);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  // undo the affine transform first, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] x);
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) b[k] = x[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[4*c+r] = gmul(b[4*c+r], 8'h0e) ^ gmul(b[4*c+(r+1)%4], 8'h0b) ^
                   gmul(b[4*c+(r+2)%4], 8'h0d) ^ gmul(b[4*c+(r+3)%4], 8'h09);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = inv_sbox(m[4*((c-r+4)%4)+r]);
    return y;
  endfunction

  assign rnd       = inv_round(st_q ^ rc_in);
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = state_q == DONE;
  assign out_data  = st_q;
  assign rc_idx    = (state_q == RUN) ? cnt_q : '0;

  // next-state: accept in IDLE, one inverse round per RUN cycle, hold in DONE until drained
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        st_d    = in_data;
        cnt_d   = LAST;
        state_d = RUN;
      end
      RUN: begin
        st_d    = rnd;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - IDXW'(1);
        state_d = (cnt_q == '0) ? DONE : RUN;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end
endmodule

// File: tb/tb_haraka_aes_inv_iter.sv
// tb_haraka_aes_inv_iter: directed and round-trip checks of the inverse round engine
module tb_haraka_aes_inv_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, rc_in, out_data;
  logic [0:0]   rc_idx;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] in_data1, rc_in1, out_data1;
  logic [0:0]   rc_idx1;
  logic [127:0] rc_tab [2];
  logic [7:0]   sb [256];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;

  always #5 clk = ~clk;

  assign rc_in  = rc_tab[rc_idx];
  assign rc_in1 = 128'ha0fafe1788542cb123a339392a6c7605;

  haraka_aes_inv_iter #(.NROUNDS(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rc_idx(rc_idx), .rc_in(rc_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  haraka_aes_inv_iter #(.NROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .rc_idx(rc_idx1), .rc_in(rc_in1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // forward step: SubBytes, ShiftRows, MixColumns, then XOR round constant
  function automatic logic [127:0] fwd(input logic [127:0] s, input logic [127:0] k);
    logic [7:0]   t [16];
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = xt(t[4*c+r]) ^ xt(t[4*c+(r+1)%4]) ^ t[4*c+(r+1)%4] ^
                                t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
    return o ^ k;
  endfunction

  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, output int acc);
    int lat;
    chk("rt_in_ready", 128'(in_ready), 128'd1);
    in_data = ct;
    tick;
    acc = cyc;
    lat = 0;
    while (!out_valid && lat < 50) begin
      chk("rt_rc_idx", 128'(rc_idx), 128'(1 - lat));
      tick;
      lat++;
    end
    chk("rt_latency", 128'(lat), 128'd2);
    chk("rt_data", out_data, exp);
  endtask

  initial begin
    logic [127:0] pt, ct, hold;
    int acc, prev;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, b;
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      b = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      sb[x] = b;
    end
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    rc_tab[0] = '0; rc_tab[1] = '0;
    tick;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_rc_idx", 128'(rc_idx), 128'd0);
    rst = 1'b0;
    tick;
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_in_ready1", 128'(in_ready1), 128'd1);

    // single-round FIPS-197 vector
    in_valid1 = 1'b1;
    in_data1 = 128'ha49c7ff2689f352b6b5bea43026a5049;
    tick;
    in_valid1 = 1'b0;
    chk("n1_rc_idx", 128'(rc_idx1), 128'd0);
    chk("n1_in_ready", 128'(in_ready1), 128'd0);
    chk("n1_run_valid", 128'(out_valid1), 128'd0);
    tick;
    chk("n1_valid", 128'(out_valid1), 128'd1);
    chk("n1_data", out_data1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    out_ready1 = 1'b1;
    tick;
    out_ready1 = 1'b0;
    chk("n1_back_idle", 128'(in_ready1), 128'd1);
    chk("n1_drained", 128'(out_valid1), 128'd0);

    // two FIPS-197 rounds, garbage on the input, long stall in DONE
    rc_tab[0] = 128'ha0fafe1788542cb123a339392a6c7605;
    rc_tab[1] = 128'hf2c295f27a96b9435935807a7359f67f;
    in_valid = 1'b1;
    in_data = 128'haa8f5f0361dde3ef82d24ad26832469a;
    tick;
    in_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    chk("n2_rc_first", 128'(rc_idx), 128'd1);
    chk("n2_run_ready", 128'(in_ready), 128'd0);
    tick;
    chk("n2_rc_second", 128'(rc_idx), 128'd0);
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1;
    in_data = 128'h0123456789abcdef0123456789abcdef;
    chk("n2_valid", 128'(out_valid), 128'd1);
    chk("n2_data", out_data, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("n2_done_rc", 128'(rc_idx), 128'd0);
    hold = out_data;
    for (int i = 0; i < 20; i++) begin
      tick;
      in_valid = ~in_valid;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_data", out_data, hold);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("drain_in_ready", 128'(in_ready), 128'd1);
    chk("drain_valid", 128'(out_valid), 128'd0);

    // reset during the first RUN cycle
    in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_data", out_data, 128'd0);
    chk("mid_rst_rc_idx", 128'(rc_idx), 128'd0);
    rst = 1'b0;
    tick;
    chk("mid_rst_idle", 128'(in_ready), 128'd1);
    chk("mid_rst_no_pulse", 128'(out_valid), 128'd0);

    // random round trips, back to back
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 1000; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      rc_tab[0] = {$urandom, $urandom, $urandom, $urandom};
      rc_tab[1] = {$urandom, $urandom, $urandom, $urandom};
      ct = fwd(fwd(pt, rc_tab[0]), rc_tab[1]);
      run_block(ct, pt, acc);
      if (i > 0) chk("rt_period", 128'(acc - prev), 128'd4);
      prev = acc;
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
